// File: rtl/req_arbiter_ctrl.sv
// req_arbiter_ctrl: fixed-priority / round-robin arbiter with a hold-time limit and timeout preemption
module req_arbiter_ctrl #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_valid,
    output logic             preempt
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [ID_W-1:0]  ptr;
    logic [HW-1:0]    hold_cnt;
    logic             own_req;
    logic             timeout;
    logic [ID_W-1:0]  base;
    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  win;
    logic             found;

    // On release or timeout the search restarts just past the outgoing owner
    always_comb begin
        own_req = req[grant_id];
        timeout = hold_cnt == HW'(MAX_HOLD);
        base    = state == BUSY ? grant_id + 1'b1 : ptr;
        cand    = (state == BUSY && own_req) ? req & ~(N_REQ'(1) << grant_id) : req;
        win     = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = rr_en ? base + ID_W'(i) : ID_W'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else if (state == IDLE) begin
            preempt <= 1'b0;
            if (found) begin
                state       <= BUSY;
                hold_cnt    <= HW'(1);
                grant       <= N_REQ'(1) << win;
                grant_id    <= win;
                grant_valid <= 1'b1;
            end
        end else if (own_req && !timeout) begin
            hold_cnt <= hold_cnt + 1'b1;
            preempt  <= 1'b0;
        end else begin
            ptr      <= grant_id + 1'b1;
            hold_cnt <= HW'(1);
            if (found) begin
                grant    <= N_REQ'(1) << win;
                grant_id <= win;
                preempt  <= own_req;
            end else if (own_req) begin
                preempt <= 1'b0;
            end else begin
                state       <= IDLE;
                hold_cnt    <= '0;
                grant       <= '0;
                grant_id    <= '0;
                grant_valid <= 1'b0;
                preempt     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_req_arbiter_ctrl.sv
// tb_req_arbiter_ctrl: directed scenarios plus random traffic against a behavioural arbiter model
module tb_req_arbiter_ctrl;
    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         rr_en = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         grant_valid;
    logic         preempt;

    int n_cmp = 0;
    int n_err = 0;

    int m_own  = -1;
    int m_hold = 0;
    int m_ptr  = 0;
    int m_pre  = 0;

    req_arbiter_ctrl #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .rr_en(rr_en),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start, input bit rr, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = rr ? (start + k) % N : k;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model(input bit r, input logic [N-1:0] q, input bit rr);
        int w, st, ex;
        m_pre = 0;
        if (r) begin
            m_own = -1; m_hold = 0; m_ptr = 0;
        end else if (m_own < 0) begin
            w = pick(q, m_ptr, rr, -1);
            if (w >= 0) begin m_own = w; m_hold = 1; end
        end else if (q[m_own] && m_hold < MH) begin
            m_hold++;
        end else begin
            st = (m_own + 1) % N;
            m_ptr = st;
            ex = q[m_own] ? m_own : -1;
            w = pick(q, st, rr, ex);
            m_hold = 1;
            if (w >= 0) begin
                m_pre = (ex >= 0);
                m_own = w;
            end else if (ex < 0) begin
                m_own = -1;
                m_hold = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] q, input bit rr);
        rst = r; req = q; rr_en = rr;
        @(posedge clk);
        model(r, q, rr);
        #1;
        check("grant", int'(grant), m_own >= 0 ? (1 << m_own) : 0);
        check("grant_id", int'(grant_id), m_own >= 0 ? m_own : 0);
        check("grant_valid", int'(grant_valid), int'(m_own >= 0));
        check("preempt", int'(preempt), m_pre);
    endtask

    initial begin
        logic [N-1:0] q;
        bit rr;
        // reset with all requests active
        cyc(1, 4'hF, 0);
        cyc(1, 4'hF, 0);
        check("t1_valid", int'(grant_valid), 0);
        // fixed priority, timeout hands over to requester 3
        cyc(0, 4'b1100, 0);
        check("t2_first_id", int'(grant_id), 2);
        for (int i = 0; i < 7; i++) cyc(0, 4'b1100, 0);
        check("t2_held", int'(grant), 4'b0100);
        cyc(0, 4'b1100, 0);
        check("t2_switch_id", int'(grant_id), 3);
        check("t2_preempt", int'(preempt), 1);
        // round-robin rotation under constant full load
        cyc(1, 4'h0, 1);
        for (int c = 0; c < 40; c++) begin
            cyc(0, 4'hF, 1);
            check("t3_id", int'(grant_id), (c / 8) % 4);
            check("t3_pre", int'(preempt), int'(c > 0 && c % 8 == 0));
        end
        // release hands over back-to-back
        cyc(1, 4'h0, 0);
        cyc(0, 4'b0010, 0);
        cyc(0, 4'b1010, 0);
        cyc(0, 4'b1010, 0);
        cyc(0, 4'b1000, 0);
        check("t4_grant", int'(grant), 4'b1000);
        check("t4_pre", int'(preempt), 0);
        // sole requester re-granted after every timeout without a gap
        cyc(1, 4'h0, 0);
        for (int c = 0; c < 20; c++) begin
            cyc(0, 4'b0100, 0);
            check("t5_grant", int'(grant), 4'b0100);
            check("t5_pre", int'(preempt), 0);
        end
        cyc(0, 4'b0000, 0);
        check("t5_idle", int'(grant_valid), 0);
        // reset in the middle of a grant clears ptr
        for (int c = 0; c < 11; c++) cyc(0, 4'hF, 1);
        cyc(1, 4'hF, 1);
        check("t6_rst", int'(grant), 0);
        cyc(0, 4'hF, 1);
        check("t6_first", int'(grant_id), 0);
        // random traffic
        q = '0;
        rr = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) q[b] = ~q[b];
            if ($urandom_range(63) == 0) rr = ~rr;
            cyc($urandom_range(199) == 0, q, rr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
